// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among four write-back requesters.
// A requester may hold the port for up to MAX_BURST consecutive grants by asserting lock.
// The selected write (enable, address, data, select) is registered toward the register file.
// Optional macro WB_ARB_ZERO_DROP_EN: granted writes to address 0 are consumed (wr_en stays 0).
module wb_port_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic             stall,
  output logic [3:0]       gnt,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [1:0]       wr_sel
);

  // Wide enough to hold MAX_BURST itself, so the release-cycle increment never wraps.
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            gnt_vld;
  logic [1:0]      gnt_idx;
  logic [1:0]      base;
  logic            run_idle;
  logic [2:0]      pick;
  logic [AW-1:0]   sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic            wr_keep;

  // Returns {found, index} of the first set request at or after base, wrapping 3 -> 0.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] b);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = b + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Grant decision and next-state for pointer, owner, burst counter and FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_vld  = 1'b0;
    gnt_idx  = 2'd0;
    run_idle = 1'b0;
    base     = ptr_q;
    pick     = 3'b000;
    if (!stall) begin
      if (state_q == StLocked) begin
        if (req[owner_q] && lock[owner_q]) begin
          gnt_vld = 1'b1;
          gnt_idx = owner_q;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(MAX_BURST - 1)) begin
            state_d = StIdle;
            ptr_d   = owner_q + 2'd1;
          end
        end else begin
          // Owner let go: release and arbitrate the others this same cycle (no bubble).
          state_d  = StIdle;
          ptr_d    = owner_q + 2'd1;
          base     = owner_q + 2'd1;
          run_idle = 1'b1;
        end
      end else begin
        run_idle = 1'b1;
      end
      if (run_idle) begin
        pick = rr_pick(req, base);
        if (pick[2]) begin
          gnt_vld = 1'b1;
          gnt_idx = pick[1:0];
          ptr_d   = pick[1:0] + 2'd1;
          if (lock[pick[1:0]]) begin
            state_d = StLocked;
            owner_d = pick[1:0];
            cnt_d   = CntW'(1);
          end
        end
      end
    end
  end

  // 4:1 write-back data/address select driven by the grant index.
  always_comb begin
    sel_addr = addr0;
    sel_data = data0;
    case (gnt_idx)
      2'd0:    begin sel_addr = addr0; sel_data = data0; end
      2'd1:    begin sel_addr = addr1; sel_data = data1; end
      2'd2:    begin sel_addr = addr2; sel_data = data2; end
      default: begin sel_addr = addr3; sel_data = data3; end
    endcase
  end

`ifdef WB_ARB_ZERO_DROP_EN
  assign wr_keep = (sel_addr != '0);
`else
  assign wr_keep = 1'b1;
`endif

  // Grant is forced low while reset is held, regardless of requests.
  assign gnt = (gnt_vld && reset_n) ? (4'b0001 << gnt_idx) : 4'b0000;

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered write toward the register file; payload holds when nothing is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_sel  <= 2'd0;
    end else if (gnt_vld && wr_keep) begin
      wr_en   <= 1'b1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      wr_sel  <= gnt_idx;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single register-file write port between four write-back requesters, such as the ALU result, load data, link address and coprocessor move. Each cycle it grants at most one requester and drives the 4:1 write-back data/address select. It registers the selected write (enable, address, data, select code) toward the register file. An optional burst lock lets one requester keep the port for consecutive cycles.

## Interface
- WIDTH, 32, write data width
- AW, 5, register address width
- MAX_BURST, 4, maximum consecutive grants to a locked owner (2..16)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  4  per-requester write request; bit i = requester i
- lock  input  4  per-requester burst-lock request; only meaningful with req[i]
- addr0..addr3  input  AW each  destination register of requester i
- data0..data3  input  WIDTH each  write data of requester i
- stall  input  1  write port unavailable this cycle; suppresses all grants
- gnt  output  4  one-hot grant, combinational, same cycle as req
- wr_en  output  1  registered register-file write enable
- wr_addr  output  AW  registered write address
- wr_data  output  WIDTH  registered write data
- wr_sel  output  2  registered index of the granted requester (mux select code)

## Operation
- State: rr pointer ptr[1:0], owner[1:0], burst counter cnt, and FSM {IDLE, LOCKED}.
- IDLE:
  - Search req starting at index ptr, ascending with wrap 3→0. The first set bit i is granted: gnt = 1<<i.
  - On a grant, ptr <= (i+1) mod 4.
  - If lock[i] is also set, go to LOCKED with owner <= i and cnt <= 1.
- LOCKED:
  - Only the owner is eligible. It is granted while req[owner] & lock[owner].
  - Each grant increments cnt.
  - When a grant occurs with cnt == MAX_BURST-1, or the owner deasserts req or lock, return to IDLE.
  - On release, ptr <= owner+1. If the owner dropped its request, no grant to the owner occurs that cycle.
  - On the release cycle caused by a dropped request, IDLE arbitration runs in the same cycle using ptr = owner+1, so the port is not left idle.
- stall = 1:
  - gnt = 0.
  - ptr, owner, cnt and FSM state hold.
  - wr_en <= 0 next edge.
- No req bits set: gnt = 0, wr_en <= 0, state holds.
- Requesters hold req, addr and data stable until granted. Dropping req before grant is legal; the request is simply withdrawn.
- Registered outputs on a grant of requester i: wr_en <= 1, wr_addr <= addr_i, wr_data <= data_i, wr_sel <= i.
- Without a grant, wr_en <= 0 and wr_addr, wr_data and wr_sel hold their last values.
- The counter is wide enough for MAX_BURST. Counting saturates by release and never wraps.

## Timing
- gnt is valid in the same cycle as req (combinational from req, lock, stall and state).
- The write appears on wr_* one cycle after the grant (latency 1). The register file commits it on the following edge.
- Maximum throughput is one write per cycle. There are no bubbles between back-to-back grants, including across a lock release.
- Reset (asynchronous, reset_n low) forces immediately:
  - wr_en=0, wr_addr=0, wr_data=0, wr_sel=0.
  - ptr=0, owner=0, cnt=0, FSM=IDLE.
  - gnt=0 while reset is asserted.
- Reset during LOCKED aborts the burst. After release, arbitration restarts from index 0.
- Simultaneous stall and lock release: stall wins, and the release is evaluated again once stall deasserts.

## Configuration
- WB_ARB_ZERO_DROP_EN defined: a granted write whose address is 0 is consumed. The grant is issued and ptr advances, but wr_en <= 0 and wr_addr/wr_data/wr_sel hold.
- Not defined: writes to address 0 pass through with wr_en=1. The register file is responsible for ignoring them.

## Test plan
- Reset, then req=4'b1111 with no lock for 4 cycles -> gnt sequence 0001, 0010, 0100, 1000; wr_sel 0,1,2,3 each one cycle later; wr_en=1 throughout.
- Requester 2 asserts req and lock for 6 cycles with MAX_BURST=4 and req=4'b1111 -> requester 2 granted 4 cycles, then gnt=1000 (ptr=3), then 0001.
- Locked owner 1 drops req after 2 grants while req[3]=1 -> same cycle gnt=1000, FSM IDLE, no idle cycle on wr_en.
- stall=1 for 3 cycles with req=4'b0101 -> gnt=0, wr_en=0 those cycles, ptr unchanged; after stall the same requester is granted as would have been before.
- reset_n pulsed low mid-burst (owner 3, cnt=2) -> all wr_* =0 immediately; after release with req=4'b1001, requester 0 granted first.
- Requester 0 writes addr=0, data=32'hDEADBEEF -> with WB_ARB_ZERO_DROP_EN, gnt=0001 and wr_en=0 next cycle; without it, wr_en=1, wr_data=32'hDEADBEEF.
